// File: rtl/text_pkg.sv
// ---------------------------------------------------------------------------
// text_pkg
// Shared definitions for the 80x30 text-mode renderer: screen geometry,
// the character byte layout stored in VRAM, the sync bundle carried down
// the delay line, and the cell-index helper.
// ---------------------------------------------------------------------------
package text_pkg;

    localparam int COLS     = 80;
    localparam int ROWS     = 30;
    localparam int CELL_W   = 8;
    localparam int CELL_H   = 16;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Font ROM address is {code[6:0], py[3:0]}
    localparam int FONT_AW  = 11;

    // One character cell as stored in a VRAM byte lane
    typedef struct packed {
        logic       inv;
        logic [6:0] code;
    } char_byte_t;

    // Sync/blank bundle delayed alongside the pixel pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    // Linear cell index row*80 + col, built from shifts so no multiplier
    // is inferred (80 = 64 + 16).
    function automatic logic [11:0] char_index(input logic [4:0] row,
                                               input logic [6:0] col);
        logic [11:0] r;
        r = {7'd0, row};
        return (r << 6) + (r << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/font_rom.sv
// ---------------------------------------------------------------------------
// font_rom
// 2048x8 synchronous glyph ROM, one byte per glyph scan line, MSB is the
// leftmost pixel. Data appears one clock after the address is presented.
// Glyphs currently populated: 'A' (0x41), 'B' (0x42), full block (0x7F);
// every other code renders as an empty cell.
//
// Ports:
//   clock  in   ROM clock
//   addr   in   {code[6:0], py[3:0]}
//   data   out  registered glyph scan line
// ---------------------------------------------------------------------------
module font_rom
    import text_pkg::*;
(
    input  logic               clock,
    input  logic [FONT_AW-1:0] addr,
    output logic [7:0]         data
);

    logic [7:0] row_bits;

    // Glyph table lookup; rows not listed for a glyph are blank.
    always_comb begin
        row_bits = 8'h00;
        case (addr[10:4])
            7'h41: begin
                case (addr[3:0])
                    4'd2:                          row_bits = 8'h10;
                    4'd3:                          row_bits = 8'h38;
                    4'd4:                          row_bits = 8'h6C;
                    4'd5, 4'd6, 4'd8, 4'd9,
                    4'd10, 4'd11:                  row_bits = 8'hC6;
                    4'd7:                          row_bits = 8'hFE;
                    default:                       row_bits = 8'h00;
                endcase
            end
            7'h42: begin
                case (addr[3:0])
                    4'd2, 4'd11:                   row_bits = 8'hFC;
                    4'd3, 4'd4, 4'd5, 4'd7,
                    4'd8, 4'd9, 4'd10:             row_bits = 8'h66;
                    4'd6:                          row_bits = 8'h7C;
                    default:                       row_bits = 8'h00;
                endcase
            end
            7'h7F:   row_bits = 8'hFF;
            default: row_bits = 8'h00;
        endcase
    end

    // Registered read port gives the one-cycle ROM latency.
    always_ff @(posedge clock) begin
        data <= row_bits;
    end

endmodule

// File: rtl/vram_text_renderer.sv
// ---------------------------------------------------------------------------
// vram_text_renderer
// Turns the current draw position into an 80x30 character-cell pixel stream.
// Four-stage pipeline, no stalls:
//   S0 register VRAM word address, byte lane, cell-local px/py, cursor hit
//   S1 pick the char byte from the VRAM word, register font address
//   S2 font_rom returns the glyph scan line
//   S3 pick the pixel bit and register RGB
// Syncs and blank travel through a matching 4-deep delay line.
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   draw_x, draw_y               current pixel position
//   blank_n, hs_in, vs_in        video timing inputs (syncs active-low)
//   cursor_col/row/en            cursor cell and enable
//   readout_addr, readout_data   read-only VRAM port (data 1 cycle later)
//   red, green, blue             pixel colour
//   hs_out, vs_out, blank_n_out  timing outputs aligned with the pixels
// ---------------------------------------------------------------------------
module vram_text_renderer
    import text_pkg::*;
#(
    parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB       = 24'h000000,
    parameter int          BLINK_FRAMES = 30
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        blank_n,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_en,
    output logic [10:0] readout_addr,
    input  logic [31:0] readout_data,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_n_out
);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int PX_W = $clog2(CELL_W);
    localparam int PY_W = $clog2(CELL_H);

    logic [FC_W-1:0]    frame_cnt;
    logic               blink_phase;
    logic               vs_prev;

    logic [6:0]         cell_col;
    logic [4:0]         cell_row;
    logic [11:0]        char_n;
    logic               in_range;
    logic               cursor_hit;

    logic               s0_valid, s0_in_range, s0_cursor;
    logic [1:0]         s0_lane;
    logic [PX_W-1:0]    s0_px;
    logic [PY_W-1:0]    s0_py;

    char_byte_t         lane_byte;
    logic               s1_valid, s1_in_range, s1_swap;
    logic [PX_W-1:0]    s1_px;
    logic [FONT_AW-1:0] font_addr;

    logic               s2_valid, s2_in_range, s2_swap;
    logic [PX_W-1:0]    s2_px;
    logic [7:0]         font_row;
    logic               pixel_on;

    sync_t              sync_pipe [4];

    // Blink timing: count vsync falling edges; every BLINK_FRAMES edges the
    // counter wraps and the cursor phase flips.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            vs_prev     <= 1'b1;
        end else begin
            vs_prev <= vs_in;
            if (vs_prev && !vs_in) begin
                if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Cell decode for the incoming pixel. Out-of-range positions still map
    // to some address; their pixels are forced dark at S3.
    assign cell_col   = draw_x[9:3];
    assign cell_row   = draw_y[8:4];
    assign char_n     = char_index(cell_row, cell_col);
    assign in_range   = (draw_x < 10'(H_ACTIVE)) && (draw_y < 10'(V_ACTIVE));
    assign cursor_hit = cursor_en && blink_phase &&
                        (cell_col == cursor_col) && (cell_row == cursor_row);

    // S0: the address register doubles as the VRAM read address register,
    // so the word is available to S1 on the next edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            readout_addr <= '0;
            s0_valid     <= 1'b0;
        end else begin
            readout_addr <= {1'b0, char_n[11:2]};
            s0_valid     <= 1'b1;
        end
        s0_lane     <= char_n[1:0];
        s0_px       <= draw_x[PX_W-1:0];
        s0_py       <= draw_y[PY_W-1:0];
        s0_in_range <= in_range;
        s0_cursor   <= cursor_hit;
    end

    // Byte lane select, lane 0 is the least significant byte.
    always_comb begin
        lane_byte = readout_data[7:0];
        case (s0_lane)
            2'd1:    lane_byte = readout_data[15:8];
            2'd2:    lane_byte = readout_data[23:16];
            2'd3:    lane_byte = readout_data[31:24];
            default: lane_byte = readout_data[7:0];
        endcase
    end

    // S1: cursor and inverse attribute fold into one swap flag since both
    // simply exchange FG and BG for the cell.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
        end
        font_addr   <= {lane_byte.code, s0_py};
        s1_swap     <= lane_byte.inv ^ s0_cursor;
        s1_px       <= s0_px;
        s1_in_range <= s0_in_range;
    end

    font_rom u_font_rom (
        .clock (clock),
        .addr  (font_addr),
        .data  (font_row)
    );

    // S2: side-band pixel state waits alongside the ROM read.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        s2_swap     <= s1_swap;
        s2_px       <= s1_px;
        s2_in_range <= s1_in_range;
    end

    assign pixel_on = font_row[3'd7 - s2_px] ^ s2_swap;

    // S3: colour out; dark whenever the pipeline is refilling after reset,
    // the position is off-screen, or the matching blank is active.
    always_ff @(posedge clock) begin
        if (reset) begin
            {red, green, blue} <= 24'h000000;
        end else if (s2_valid && s2_in_range && sync_pipe[2].blank_n) begin
            {red, green, blue} <= pixel_on ? FG_RGB : BG_RGB;
        end else begin
            {red, green, blue} <= 24'h000000;
        end
    end

    // Timing delay line matched to the four pixel stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                sync_pipe[i] <= SYNC_IDLE;
            end
        end else begin
            sync_pipe[0] <= {hs_in, vs_in, blank_n};
            for (int i = 1; i < 4; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign hs_out      = sync_pipe[3].hs;
    assign vs_out      = sync_pipe[3].vs;
    assign blank_n_out = sync_pipe[3].blank_n;

endmodule

// File: tb/tb_vram_text_renderer.sv
// ---------------------------------------------------------------------------
// tb_vram_text_renderer
// Scoreboard bench: each driven pixel pushes its expected output; a monitor
// pops and compares once the 4-cycle pipeline has delivered it.
// ---------------------------------------------------------------------------
module tb_vram_text_renderer;

    localparam logic [23:0]  FG      = 24'hF0A050;
    localparam logic [23:0]  BG      = 24'h102030;
    localparam logic [127:0] GLYPH_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [127:0] GLYPH_B = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic [9:0]  draw_x     = '0;
    logic [9:0]  draw_y     = '0;
    logic        blank_n    = 1'b0;
    logic        hs_in      = 1'b1;
    logic        vs_in      = 1'b1;
    logic [6:0]  cursor_col = 7'd5;
    logic [4:0]  cursor_row = 5'd2;
    logic        cursor_en  = 1'b0;
    logic [10:0] readout_addr;
    logic [31:0] readout_data;
    logic [7:0]  red, green, blue;
    logic        hs_out, vs_out, blank_n_out;

    logic [31:0] vram [0:2047];
    logic        exp_blink = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic        rst;
        int          x;
        int          y;
        logic [10:0] addr;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank_n;
    } exp_t;

    exp_t sb_q[$];

    // Read-only VRAM: the DUT's registered address selects the word directly
    assign readout_data = vram[readout_addr];

    vram_text_renderer #(
        .FG_RGB       (FG),
        .BG_RGB       (BG),
        .BLINK_FRAMES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .blank_n      (blank_n),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .cursor_en    (cursor_en),
        .readout_addr (readout_addr),
        .readout_data (readout_data),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .blank_n_out  (blank_n_out)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] glyph_row(input logic [6:0] code, input int py);
        logic [127:0] g;
        case (code)
            7'h41:   g = GLYPH_A;
            7'h42:   g = GLYPH_B;
            default: g = '0;
        endcase
        return g[127 - 8*py -: 8];
    endfunction

    function automatic exp_t expect_pixel(input logic rst, input int x, input int y,
                                          input logic b, input logic hs, input logic vs,
                                          input logic cen, input logic blink);
        exp_t        e;
        int          col, row, n;
        logic [31:0] word;
        logic [7:0]  cb, gr;
        logic        cur, lit;
        col    = x / 8;
        row    = (y / 16) % 32;
        n      = row * 80 + col;
        word   = vram[n / 4];
        cb     = 8'(word >> (8 * (n % 4)));
        gr     = glyph_row(cb[6:0], y % 16);
        cur    = cen && blink && (col == 5) && (row == 2);
        lit    = gr[7 - (x % 8)] ^ cb[7] ^ cur;
        e.rst     = rst;
        e.x       = x;
        e.y       = y;
        e.addr    = 11'(n / 4);
        e.rgb     = (b && x < 640 && y < 480) ? (lit ? FG : BG) : 24'h000000;
        e.hs      = hs;
        e.vs      = vs;
        e.blank_n = b;
        return e;
    endfunction

    task automatic apply_stimulus(input logic rst, input int x, input int y, input logic b,
                                  input logic hs, input logic vs, input logic cen);
        @(negedge clock);
        reset     = rst;
        draw_x    = 10'(x);
        draw_y    = 10'(y);
        blank_n   = b;
        hs_in     = hs;
        vs_in     = vs;
        cursor_en = cen;
        sb_q.push_back(expect_pixel(rst, x, y, b, hs, vs, cen, exp_blink));
    endtask

    task automatic scan(input int y, input int x0, input int x1, input logic cen);
        for (int x = x0; x <= x1; x++) begin
            apply_stimulus(1'b0, x, y, 1'b1, 1'b1, 1'b1, cen);
        end
    endtask

    task automatic vsync_pulse();
        apply_stimulus(1'b0, 700, 500, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) apply_stimulus(1'b0, 700, 500, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 700, 500, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    // Queue holds items for the last four edges: the newest one is what the
    // address register just took, the oldest is what RGB now shows.
    task automatic check_output();
        exp_t        e;
        logic        any_rst;
        logic [10:0] want_addr;
        logic [23:0] want_rgb;
        logic        want_hs, want_vs, want_b;
        e         = sb_q[0];
        any_rst   = sb_q[0].rst | sb_q[1].rst | sb_q[2].rst | sb_q[3].rst;
        want_addr = sb_q[3].rst ? 11'd0 : sb_q[3].addr;
        n_cmp++;
        if (readout_addr !== want_addr) begin
            n_bad++;
            $display("[TB] FAIL addr x=%0d y=%0d: got %0d, expected %0d",
                     sb_q[3].x, sb_q[3].y, readout_addr, want_addr);
        end
        if (any_rst) begin
            want_rgb = 24'h000000;
            want_hs  = 1'b1;
            want_vs  = 1'b1;
            want_b   = 1'b0;
        end else begin
            want_rgb = e.rgb;
            want_hs  = e.hs;
            want_vs  = e.vs;
            want_b   = e.blank_n;
        end
        n_cmp++;
        if ({red, green, blue, hs_out, vs_out, blank_n_out} !== {want_rgb, want_hs, want_vs, want_b}) begin
            n_bad++;
            $display("[TB] FAIL pix x=%0d y=%0d: got rgb=%h hs=%b vs=%b bn=%b, expected rgb=%h hs=%b vs=%b bn=%b",
                     e.x, e.y, {red, green, blue}, hs_out, vs_out, blank_n_out,
                     want_rgb, want_hs, want_vs, want_b);
        end
        void'(sb_q.pop_front());
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 3) check_output();
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: stimulus did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Stimulus
    initial begin
        for (int i = 0; i < 2048; i++) vram[i] = 32'h0;
        vram[0]   = 32'h0000_4241;   // 'A' at n=0, 'B' at n=1
        vram[1]   = 32'h0042_C120;   // space, inverse 'A', 'B', blank
        vram[9]   = 32'h4142_4100;   // n=37..39: 'A','B','A'
        vram[41]  = 32'h0000_4100;   // n=165 (row 2, col 5): 'A' under cursor
        vram[599] = 32'h4142_0000;   // n=2398 'B', n=2399 'A'

        repeat (4) apply_stimulus(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);

        // 'A' then 'B' at the top-left, glyph rows 0 and 5
        scan(0, 0, 15, 1'b1);
        scan(5, 0, 15, 1'b1);
        // space, inverse 'A', 'B'
        scan(6, 32, 63, 1'b1);
        // last cells of the screen then off-screen columns
        scan(469, 624, 655, 1'b1);
        scan(479, 632, 639, 1'b1);
        scan(480, 0, 7, 1'b1);

        // 10-cycle blank pulse with an hsync inside it
        for (int x = 0; x < 30; x++) begin
            apply_stimulus(1'b0, x, 7, !(x >= 10 && x < 20), !(x >= 12 && x < 16), 1'b1, 1'b1);
        end

        // Cursor blink, frames 0..3: normal, normal, inverted, inverted
        for (int f = 0; f < 4; f++) begin
            if (f > 0) vsync_pulse();
            exp_blink = (f == 2 || f == 3);
            scan(37, 32, 55, 1'b1);
            if (f == 2) scan(37, 32, 55, 1'b0);
        end

        // Reset for 3 cycles mid-line while the cursor is in its inverted phase
        for (int x = 290; x <= 320; x++) begin
            apply_stimulus((x >= 300 && x < 303), x, 5, 1'b1, 1'b1, 1'b1, 1'b1);
        end

        // Blink restarts from frame 0 after reset: 0,0,1,1,0,0
        for (int f = 0; f < 6; f++) begin
            if (f > 0) vsync_pulse();
            exp_blink = (f == 2 || f == 3);
            scan(37, 32, 55, 1'b1);
        end

        repeat (6) apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_text_renderer.md
VRAM_TEXT_RENDERER -- requirements
Module: vram_text_renderer

Interface
REQ-001 SHALL have parameter FG_RGB, 24'hFFFFFF, foreground pixel colour {R,G,B}.
REQ-002 SHALL have parameter BG_RGB, 24'h000000, background pixel colour.
REQ-003 SHALL have parameter BLINK_FRAMES, 30, vsync frames per cursor blink half-period.
REQ-004 clock  in  1  single clock, shared with VRAM readout port.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 draw_x  in  10  current pixel column, 0..639 active.
REQ-007 draw_y  in  10  current pixel row, 0..479 active.
REQ-008 blank_n  in  1  high during active video.
REQ-009 hs_in, vs_in  in  1 each  sync pulses, active-low.
REQ-010 cursor_col  in  7  cursor column 0..79.
REQ-011 cursor_row  in  5  cursor row 0..29.
REQ-012 cursor_en  in  1  cursor display enable.
REQ-013 readout_addr  out  11  VRAM word address.
REQ-014 readout_data  in  32  VRAM word, valid 1 cycle after readout_addr is registered.
REQ-015 red, green, blue  out  8 each  pixel colour.
REQ-016 hs_out, vs_out, blank_n_out  out  1 each  syncs and blank, delayed to match the pixels.

Function
REQ-017 Screen SHALL be 80x30 cells of 8x16 pixels; col = draw_x[9:3], row = draw_y[8:4], px = draw_x[2:0], py = draw_y[3:0].
REQ-018 Char index SHALL be n = row*80 + col (12 bits); readout_addr = n[11:2]; byte lane = n[1:0], lane 0 = bits 7:0.
REQ-019 Char byte SHALL be {inv, code[6:0]}; inv=1 swaps FG/BG for the whole cell.
REQ-020 Pipeline: S0 registers readout_addr and lane; S1 captures readout_data, selects byte, registers font address {code,py}; S2 font_rom returns 8-bit row; S3 selects bit 7-px (MSB = leftmost) and registers RGB.
REQ-021 Total latency from draw_x/draw_y to red/green/blue SHALL be exactly 4 cycles; hs/vs/blank_n SHALL pass through a matching 4-stage delay.
REQ-022 When delayed blank_n is 0, RGB SHALL be 0.
REQ-023 Frame counter SHALL increment on each vs_in falling edge; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
REQ-024 Cell at (cursor_row, cursor_col) SHALL render with FG/BG swapped (XOR with inv) when cursor_en=1 and blink_phase=1.
REQ-025 Cursor position SHALL be sampled at S0 with the pixel and carried through the pipeline.
REQ-026 Out-of-range coordinates (x>639 or y>479) SHALL still issue addresses (don't-care data) but output RGB=0.
REQ-027 The block SHALL never write VRAM; readout is continuous, with no stalls.

Reset
REQ-028 While reset=1: readout_addr=0, RGB=0, hs_out=vs_out=1, blank_n_out=0, frame counter=0, blink_phase=0, all pipeline valid bits clear.
REQ-029 Reset mid-frame SHALL blank output for 4 cycles after release, then resume at the current draw_x/draw_y.

Structure
REQ-030 Shared package text_pkg SHALL hold COLS=80, ROWS=30, CELL_W=8, CELL_H=16, H_ACTIVE=640, V_ACTIVE=480, and the char-byte struct {inv, code}.
REQ-031 Glyph storage SHALL be sub-module font_rom: 2048x8 synchronous ROM, 11-bit address {code,py}, 1-cycle latency.
REQ-032 row*80 SHALL be computed as (row<<6)+(row<<4), with no multiplier.

Verification
REQ-033 VRAM word 0 = 32'h00004241, scan y=0, x=0..15 -> readout_addr=0, glyphs 'A' then 'B' appear 4 cycles after their draw_x, pixels match font row 0.
REQ-034 draw_x=632, draw_y=464 (cell 79,29, n=2399) -> readout_addr=599, lane 3.
REQ-035 Char byte 8'hC1 -> cell 'A' with FG/BG swapped; 8'h20 -> all BG.
REQ-036 cursor_en=1, cursor at (5,2), BLINK_FRAMES=2 -> cell inverted on frames 2-3, normal on 0-1 and 4-5.
REQ-037 blank_n=0 pulse of 10 cycles -> RGB=0 and blank_n_out=0 for exactly those 10 cycles, delayed by 4.
REQ-038 reset asserted at x=300 for 3 cycles -> outputs per REQ-028; correct pixels resume 4 cycles after release.
